// File: rtl/uart_pkg.sv
// Shared UART constants: ASCII codes used by the TX formatters and the
// formatter state encoding.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_X  = 8'h78;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Maps one 4-bit nibble to its uppercase ASCII hex digit ('0'-'9', 'A'-'F').
module hex_nibble_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Decimal digits offset from '0', letters offset from 'A'.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'b0000, nibble};
    end else begin
      ascii = ASCII_A + ({4'b0000, nibble} - 8'd10);
    end
  end

endmodule

// File: rtl/uart_hex_tx_formatter.sv
// Prints a latched binary word as uppercase ASCII hex into the UART TX FIFO,
// MSB nibble first, with optional "0x" prefix and CR/LF suffix. One
// character per cycle, throttled by the FIFO full flag.
module uart_hex_tx_formatter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit PREFIX_0X   = 1'b0,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                  fifo_tx_clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] value,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_full,
  output logic                  fifo_tx_req,
  output logic [7:0]            fifo_tx_data
);

  localparam int PRE_N  = PREFIX_0X ? 2 : 0;
  localparam int DIG_N  = DATA_WIDTH / 4;
  localparam int SUF_N  = APPEND_CRLF ? 2 : 0;
  localparam int CHAR_N = PRE_N + DIG_N + SUF_N;
  // A one-character string still needs a 1-bit index.
  localparam int IDX_W  = (CHAR_N > 1) ? $clog2(CHAR_N) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAR_N - 1);
  localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(PRE_N + DIG_N);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] word;
  logic [3:0]            nibble;
  logic [7:0]            digit_char;
  logic [7:0]            char_sel;

  // Write only while sending and the FIFO has room; a full flag rising
  // suppresses the write in the same cycle.
  assign fifo_tx_req  = (state == ST_SEND) && !fifo_full;
  assign busy         = (state == ST_SEND);
  assign done         = (state == ST_DONE);
  assign fifo_tx_data = char_sel;

  // Pick the nibble addressed by the current index, MSB nibble first.
  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < DIG_N; i++) begin
      if (idx == IDX_W'(PRE_N + i)) begin
        nibble = word[DATA_WIDTH-1-4*i -: 4];
      end
    end
  end

  hex_nibble_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (digit_char)
  );

  // Character decode from the registered index; forced to 0x00 outside
  // SEND so the data bus idles at a defined value.
  always_comb begin
    char_sel = digit_char;
    if ((PRE_N != 0) && (idx == '0)) begin
      char_sel = ASCII_0;
    end else if ((PRE_N != 0) && (idx == IDX_W'(1))) begin
      char_sel = ASCII_X;
    end else if ((SUF_N != 0) && (idx == CR_IDX)) begin
      char_sel = ASCII_CR;
    end else if ((SUF_N != 0) && (idx == LAST_IDX)) begin
      char_sel = ASCII_LF;
    end
    if (state != ST_SEND) begin
      char_sel = 8'h00;
    end
  end

  // Control FSM: latch on start, step the index on each accepted write,
  // one DONE cycle after the last character.
  always_ff @(posedge fifo_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      word  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            word  <= value;
            idx   <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (fifo_tx_req) begin
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_tx_formatter.sv
// Bench for uart_hex_tx_formatter: a default 32-bit instance (no prefix,
// CR/LF) and an 8-bit instance ("0x" prefix, no CR/LF). Expected strings
// are queued when a print is requested; per-instance monitors pop and
// compare on every FIFO write.
module tb_uart_hex_tx_formatter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b, full_a, full_b;
  logic [31:0] value_a;
  logic [7:0]  value_b;
  logic        busy_a, done_a, req_a, busy_b, done_b, req_b;
  logic [7:0]  data_a, data_b;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  int          checks = 0;
  int          fails  = 0;
  int          dones_a = 0;
  int          dones_b = 0;

  always #5 clk = ~clk;

  uart_hex_tx_formatter #(
    .DATA_WIDTH  (32),
    .PREFIX_0X   (1'b0),
    .APPEND_CRLF (1'b1)
  ) dut_a (
    .fifo_tx_clk  (clk),
    .reset_n      (reset_n),
    .start        (start_a),
    .value        (value_a),
    .busy         (busy_a),
    .done         (done_a),
    .fifo_full    (full_a),
    .fifo_tx_req  (req_a),
    .fifo_tx_data (data_a)
  );

  uart_hex_tx_formatter #(
    .DATA_WIDTH  (8),
    .PREFIX_0X   (1'b1),
    .APPEND_CRLF (1'b0)
  ) dut_b (
    .fifo_tx_clk  (clk),
    .reset_n      (reset_n),
    .start        (start_b),
    .value        (value_b),
    .busy         (busy_b),
    .done         (done_b),
    .fifo_full    (full_b),
    .fifo_tx_req  (req_b),
    .fifo_tx_data (data_b)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit g_req(input bit s);
    return s ? req_b : req_a;
  endfunction
  function automatic bit g_busy(input bit s);
    return s ? busy_b : busy_a;
  endfunction
  function automatic bit g_done(input bit s);
    return s ? done_b : done_a;
  endfunction

  task automatic set_full(input bit s, input bit f);
    if (s) full_b = f;
    else   full_a = f;
  endtask

  task automatic set_start(input bit s, input bit st, input logic [31:0] v);
    if (s) begin
      start_b = st;
      value_b = v[7:0];
    end else begin
      start_a = st;
      value_a = v;
    end
  endtask

  // Reference string: optional "0x", hex digits MSB first, optional CR LF.
  task automatic push_exp(input bit s, input logic [31:0] v);
    string      hexd = "0123456789ABCDEF";
    int         nd;
    logic [7:0] str[$];
    nd = s ? 2 : 8;
    if (s) begin
      str.push_back("0");
      str.push_back("x");
    end
    for (int i = nd - 1; i >= 0; i--) begin
      str.push_back(hexd[int'((v >> (4 * i)) & 32'hF)]);
    end
    if (!s) begin
      str.push_back(8'h0D);
      str.push_back(8'h0A);
    end
    foreach (str[k]) begin
      if (s) qb.push_back(str[k]);
      else   qa.push_back(str[k]);
    end
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (reset_n) begin
      if (full_a) chk("a_req_while_full", req_a, 0);
      if (req_a) begin
        chk("a_busy_during_write", busy_a, 1);
        if (qa.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL a_unexpected_write: got %h, expected no write (t=%0t)", data_a, $time);
        end else begin
          chk("a_char", data_a, qa.pop_front());
        end
      end
      if (done_a) begin
        dones_a++;
        chk("a_busy_at_done", busy_a, 0);
        chk("a_pending_at_done", qa.size(), 0);
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (reset_n) begin
      if (full_b) chk("b_req_while_full", req_b, 0);
      if (req_b) begin
        chk("b_busy_during_write", busy_b, 1);
        if (qb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL b_unexpected_write: got %h, expected no write (t=%0t)", data_b, $time);
        end else begin
          chk("b_char", data_b, qb.pop_front());
        end
      end
      if (done_b) begin
        dones_b++;
        chk("b_busy_at_done", busy_b, 0);
        chk("b_pending_at_done", qb.size(), 0);
      end
    end
  end

  // One print transaction. stall_after/stall_len: hold full for stall_len
  // cycles after that many writes. pre_full: full high on the start cycle
  // and that many cycles after. rnd: random full and random start pulses.
  // restart_at: pulse start with all-ones on that cycle. reset_after:
  // assert reset once that many characters have been written.
  task automatic run(input bit s, input logic [31:0] v, input int stall_after,
                     input int stall_len, input int pre_full, input bit rnd,
                     input int restart_at, input int reset_after);
    int n, cyc, writes, stall, first_w, done_cyc, d0;
    bit stalled, got_done;
    n = s ? 4 : 10;
    cyc = 0;
    while ((g_busy(s) || g_done(s)) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    d0 = s ? dones_b : dones_a;
    set_full(s, pre_full > 0);
    set_start(s, 1'b1, v);
    push_exp(s, v);
    stall = pre_full; writes = 0; first_w = -1; done_cyc = -1;
    cyc = 0; got_done = 0; stalled = 0;
    while (!got_done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (rnd) begin
        set_start(s, ($urandom % 4) == 0, $urandom);
        set_full(s, ($urandom % 3) == 0);
      end else begin
        if (cyc == restart_at) set_start(s, 1'b1, 32'hFFFF_FFFF);
        else                   set_start(s, 1'b0, ~v);
        if (stall > 0) begin
          set_full(s, 1'b1);
          stall--;
        end else begin
          set_full(s, 1'b0);
        end
      end
      #1;
      if (reset_after > 0 && writes == reset_after) begin
        reset_n = 1'b0;
        #1;
        chk("rst_req_low", g_req(s), 0);
        chk("rst_busy_low", g_busy(s), 0);
        chk("rst_data_zero", s ? data_b : data_a, 0);
        if (s) qb.delete();
        else   qa.delete();
        set_full(s, 1'b0);
        set_start(s, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) begin
          @(posedge clk); #1;
          chk("rst_no_done", g_done(s), 0);
        end
        chk("rst_done_count", (s ? dones_b : dones_a) - d0, 0);
        return;
      end
      if (g_req(s)) begin
        writes++;
        if (first_w < 0) first_w = cyc;
        if (stall_after > 0 && writes == stall_after && !stalled) begin
          stall = stall_len;
          stalled = 1;
        end
      end
      if (g_done(s)) begin
        got_done = 1;
        done_cyc = cyc;
      end
    end
    chk("done_seen", got_done, 1);
    if (!rnd) begin
      chk("first_write_cycle", first_w, 1 + pre_full);
      chk("done_cycle", done_cyc, n + 1 + pre_full + ((stall_after > 0) ? stall_len : 0));
    end
    // Any start left high here lands in the DONE cycle and must be ignored.
    @(posedge clk); #1;
    set_start(s, 1'b0, $urandom);
    set_full(s, 1'b0);
    chk("done_one_cycle", g_done(s), 0);
    @(negedge clk); #1;
    chk("done_count", (s ? dones_b : dones_a) - d0, 1);
    chk("queue_drained", s ? qb.size() : qa.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    full_a  = 1'b0; full_b  = 1'b0;
    value_a = '0;   value_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_a", busy_a, 0);
    chk("reset_done_a", done_a, 0);
    chk("reset_req_a", req_a, 0);
    chk("reset_data_a", data_a, 0);
    chk("reset_busy_b", busy_b, 0);
    chk("reset_done_b", done_b, 0);
    chk("reset_req_b", req_b, 0);
    chk("reset_data_b", data_b, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run(0, 32'h1234ABCD, 0, 0, 0, 0, 0, 0);   // plain stream
    run(0, 32'h1234ABCD, 3, 5, 0, 0, 0, 0);   // 5-cycle stall after 3rd write
    run(0, 32'h1234ABCD, 0, 0, 0, 0, 3, 0);   // start while busy
    run(1, 32'h0000000F, 0, 0, 0, 0, 0, 0);   // "0x0F"
    run(0, 32'h1234ABCD, 0, 0, 0, 0, 0, 4);   // reset after 4th char
    run(0, 32'h00000000, 0, 0, 0, 0, 0, 0);   // fresh print after reset
    run(0, 32'h1234ABCD, 0, 0, 3, 0, 0, 0);   // full at start for 3 cycles
    run(0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    run(1, 32'h000000A9, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 25; i++) run(0, $urandom, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) run(1, $urandom, 0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
